shifter_operand_unit: RTL and testbench

- Parametrised, pipelined successor to the EXE-stage second-operand generator.
- Produces Val2 and the shifter carry-out for data-processing and memory instructions.
- Adds register-specified shift amounts, ARM-exact carry semantics, a valid/ready handshake and a 2-stage pipeline with flush.
- Sits between the ID/EX register and the ALU/address adder.

---
 rtl/shifter_pkg.sv | 22 ++
 rtl/barrel_shift_core.sv | 62 ++++++
 rtl/shifter_operand_unit.sv | 153 +++++++++++++++
 tb/tb_shifter_operand_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared encodings and result payload for the shifter operand unit.
package shifter_pkg;

  localparam int unsigned MAX_W = 64;

  localparam logic [1:0] MODE_IMM_ROT = 2'b00;
  localparam logic [1:0] MODE_REG_IMM = 2'b01;
  localparam logic [1:0] MODE_REG_REG = 2'b10;
  localparam logic [1:0] MODE_MEM_OFS = 2'b11;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Sized for the widest legal operand; narrower builds use the low bits.
  typedef struct packed {
    logic [MAX_W-1:0] val2;
    logic             carry;
  } shift_res_t;

endpackage

// File: rtl/barrel_shift_core.sv
// Single-cycle barrel shifter with ARM register-shift carry semantics (amount 0..255).
module barrel_shift_core
  import shifter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] value,
  input  logic [1:0]        sh_type,
  input  logic [7:0]        amt,
  input  logic              carry_in,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  localparam int unsigned ROT_W = $clog2(DATA_W);

  logic [7:0]               amt_c;
  logic [DATA_W:0]          lsl_w;
  logic [DATA_W:0]          lsr_w;
  logic signed [DATA_W:0]   asr_in;
  logic signed [DATA_W:0]   asr_w;
  logic [ROT_W-1:0]         rot;
  logic [ROT_W-1:0]         rot_neg;
  logic [DATA_W-1:0]        ror_w;

  // Shifts carry one guard bit so the last bit shifted out lands in a fixed slot;
  // amounts beyond DATA_W clamp to DATA_W+1, which shifts everything out.
  always_comb begin
    amt_c   = (amt > 8'(DATA_W)) ? 8'(DATA_W + 1) : amt;
    lsl_w   = {1'b0, value} << amt_c;
    lsr_w   = {value, 1'b0} >> amt_c;
    asr_in  = {value, 1'b0};
    asr_w   = asr_in >>> amt_c;
    rot     = amt[ROT_W-1:0];
    rot_neg = -rot;
    ror_w   = (value >> rot) | (value << rot_neg);

    result = value;
    carry  = carry_in;
    if (amt != 8'd0) begin
      unique case (sh_type)
        SH_LSL: begin
          result = lsl_w[DATA_W-1:0];
          carry  = lsl_w[DATA_W];
        end
        SH_LSR: begin
          result = lsr_w[DATA_W:1];
          carry  = lsr_w[0];
        end
        SH_ASR: begin
          result = asr_w[DATA_W:1];
          carry  = asr_w[0];
        end
        default: begin
          result = ror_w;
          carry  = ror_w[DATA_W-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/shifter_operand_unit.sv
// Two-stage valid/ready pipeline producing Val2 and shifter carry for the EXE stage.
// Optional RRX_EN: mode 01 ROR #0 performs RRX instead of passing rm through.
module shifter_operand_unit
  import shifter_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [11:0]       shifter,
  input  logic [DATA_W-1:0] rm,
  input  logic [7:0]        rs_low,
  input  logic              carry_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out,
  output logic [TAG_W-1:0]  tag_out
);

  logic              s1_valid;
  logic [1:0]        s1_mode;
  logic [11:0]       s1_shifter;
  logic [DATA_W-1:0] s1_rm;
  logic [7:0]        s1_rs_low;
  logic              s1_carry_in;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_adv;
  logic              s1_adv;

  logic [DATA_W-1:0] core_value;
  logic [1:0]        core_type;
  logic [7:0]        core_amt;
  logic [DATA_W-1:0] core_result;
  logic              core_carry;
  shift_res_t        res_c;
`ifdef RRX_EN
  logic              rrx_sel;
`endif

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s2_adv || !s1_valid;
  assign in_ready = !s1_valid || s1_adv;

  // Map each addressing mode onto the generic register-shift core.
  always_comb begin
    core_value = s1_rm;
    core_type  = s1_shifter[6:5];
    core_amt   = {3'b000, s1_shifter[11:7]};
`ifdef RRX_EN
    rrx_sel    = 1'b0;
`endif
    unique case (s1_mode)
      MODE_IMM_ROT: begin
        core_value = DATA_W'(s1_shifter[7:0]);
        core_type  = SH_ROR;
        core_amt   = {3'b000, s1_shifter[11:8], 1'b0};
      end
      MODE_REG_IMM: begin
        if (s1_shifter[11:7] == 5'd0 &&
            (s1_shifter[6:5] == SH_LSR || s1_shifter[6:5] == SH_ASR)) begin
          core_amt = 8'd32;
        end
`ifdef RRX_EN
        rrx_sel = (s1_shifter[11:7] == 5'd0) && (s1_shifter[6:5] == SH_ROR);
`endif
      end
      MODE_REG_REG: core_amt = s1_rs_low;
      default: ;
    endcase
  end

  barrel_shift_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .value    (core_value),
    .sh_type  (core_type),
    .amt      (core_amt),
    .carry_in (s1_carry_in),
    .result   (core_result),
    .carry    (core_carry)
  );

  // Final operand select: memory offsets and RRX bypass the shifter result.
  always_comb begin
    res_c.val2  = MAX_W'(core_result);
    res_c.carry = core_carry;
    if (s1_mode == MODE_MEM_OFS) begin
      res_c.val2  = MAX_W'({{(DATA_W-12){s1_shifter[11]}}, s1_shifter});
      res_c.carry = s1_carry_in;
    end
`ifdef RRX_EN
    else if (rrx_sel) begin
      res_c.val2  = MAX_W'({s1_carry_in, s1_rm[DATA_W-1:1]});
      res_c.carry = s1_rm[0];
    end
`endif
  end

  if (DATA_W < MAX_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^res_c.val2[MAX_W-1:DATA_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid    <= 1'b0;
      s1_mode     <= '0;
      s1_shifter  <= '0;
      s1_rm       <= '0;
      s1_rs_low   <= '0;
      s1_carry_in <= 1'b0;
      s1_tag      <= '0;
      out_valid   <= 1'b0;
      val2        <= '0;
      carry_out   <= 1'b0;
      tag_out     <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_mode     <= mode;
        s1_shifter  <= shifter;
        s1_rm       <= rm;
        s1_rs_low   <= rs_low;
        s1_carry_in <= carry_in;
        s1_tag      <= tag_in;
      end

      if (flush) begin
        out_valid <= 1'b0;
      end else if (s2_adv) begin
        out_valid <= s1_valid;
      end
      if (s2_adv && s1_valid) begin
        val2      <= DATA_W'(res_c.val2);
        carry_out <= res_c.carry;
        tag_out   <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_shifter_operand_unit.sv
// Self-checking bench for shifter_operand_unit: vector table, scoreboard, flush/reset sequences.
module tb_shifter_operand_unit;
  import shifter_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;
  localparam int NV = 18;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        mode = '0;
  logic [11:0]       shifter = '0;
  logic [DATA_W-1:0] rm = '0;
  logic [7:0]        rs_low = '0;
  logic              carry_in = 1'b0;
  logic [TAG_W-1:0]  tag_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] val2;
  logic              carry_out;
  logic [TAG_W-1:0]  tag_out;

  shifter_operand_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .shifter(shifter), .rm(rm), .rs_low(rs_low), .carry_in(carry_in),
    .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready), .val2(val2),
    .carry_out(carry_out), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] shifter;
    logic [31:0] rm;
    logic [7:0]  rs;
    logic        cin;
    logic [31:0] v;
    logic        c;
  } vec_t;

  typedef struct {
    logic [31:0] v;
    logic        c;
    logic [3:0]  tag;
  } exp_t;

  vec_t vecs[NV];
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_vecs();
    vecs[0]  = '{MODE_IMM_ROT, 12'h4FF, 32'h0,        8'd0,   1'b0, 32'hFF000000, 1'b1};
    vecs[1]  = '{MODE_IMM_ROT, 12'h0AB, 32'h0,        8'd0,   1'b1, 32'h000000AB, 1'b1};
    vecs[2]  = '{MODE_REG_REG, 12'h000, 32'h80000001, 8'd32,  1'b0, 32'h00000000, 1'b1};
    vecs[3]  = '{MODE_REG_REG, 12'h000, 32'h80000001, 8'd33,  1'b1, 32'h00000000, 1'b0};
    vecs[4]  = '{MODE_REG_REG, 12'h040, 32'h80000001, 8'd200, 1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{MODE_REG_REG, 12'h060, 32'h80000001, 8'd64,  1'b0, 32'h80000001, 1'b1};
    vecs[6]  = '{MODE_REG_REG, 12'h020, 32'h80000001, 8'd32,  1'b0, 32'h00000000, 1'b1};
    vecs[7]  = '{MODE_REG_REG, 12'h060, 32'h80000001, 8'd0,   1'b0, 32'h80000001, 1'b0};
    vecs[8]  = '{MODE_REG_REG, 12'h000, 32'hF0000001, 8'd4,   1'b0, 32'h00000010, 1'b1};
    vecs[9]  = '{MODE_REG_IMM, 12'h020, 32'h80000000, 8'd0,   1'b0, 32'h00000000, 1'b1};
`ifdef RRX_EN
    vecs[10] = '{MODE_REG_IMM, 12'h060, 32'h00000003, 8'd0,   1'b1, 32'h80000001, 1'b1};
`else
    vecs[10] = '{MODE_REG_IMM, 12'h060, 32'h00000003, 8'd0,   1'b1, 32'h00000003, 1'b1};
`endif
    vecs[11] = '{MODE_REG_IMM, 12'h240, 32'h80000018, 8'd0,   1'b0, 32'hF8000001, 1'b1};
    vecs[12] = '{MODE_REG_IMM, 12'h000, 32'h12345678, 8'd0,   1'b1, 32'h12345678, 1'b1};
    vecs[13] = '{MODE_REG_IMM, 12'h460, 32'h000000FF, 8'd0,   1'b0, 32'hFF000000, 1'b1};
    vecs[14] = '{MODE_MEM_OFS, 12'hFFC, 32'h0,        8'd0,   1'b1, 32'hFFFFFFFC, 1'b1};
    vecs[15] = '{MODE_MEM_OFS, 12'h123, 32'hFFFFFFFF, 8'd0,   1'b0, 32'h00000123, 1'b0};
    vecs[16] = '{MODE_REG_REG, 12'h060, 32'h0000000F, 8'd4,   1'b0, 32'hF0000000, 1'b1};
    vecs[17] = '{MODE_REG_REG, 12'h020, 32'h80000001, 8'd33,  1'b1, 32'h00000000, 1'b0};
  endtask

  task automatic drive_vec(input int i, input logic [3:0] tag);
    mode     = vecs[i].mode;
    shifter  = vecs[i].shifter;
    rm       = vecs[i].rm;
    rs_low   = vecs[i].rs;
    carry_in = vecs[i].cin;
    tag_in   = tag;
    in_valid = 1'b1;
  endtask

  // One isolated op; result must be visible after the second rising edge.
  task automatic single_op(input string nm, input int i, input logic [3:0] tag);
    @(negedge clk); #1;
    out_ready = 1'b1;
    drive_vec(i, tag);
    #1 check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk); #1;
    in_valid = 1'b0;
    #1 check({nm, "_early_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk); #2;
    check({nm, "_valid"}, 64'(out_valid), 64'd1);
    check({nm, "_val2"}, 64'(val2), 64'(vecs[i].v));
    check({nm, "_carry"}, 64'(carry_out), 64'(vecs[i].c));
    check({nm, "_tag"}, 64'(tag_out), 64'(tag));
  endtask

  task automatic stream(input bit rand_ready);
    int i = 0;
    int guard = 0;
    while (i < NV && guard < 2000) begin
      @(negedge clk); #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_vec(i, 4'(i));
      #1;
      if (in_ready) begin
        sb.push_back('{vecs[i].v, vecs[i].c, 4'(i)});
        i++;
      end
      guard++;
    end
    check("stream_accepted", 64'(i), 64'(NV));
    guard = 0;
    @(negedge clk); #1;
    in_valid = 1'b0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk); #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      guard++;
    end
    repeat (2) @(negedge clk);
    check("stream_drained", 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: pops scoreboard on transfer, checks hold stability on stall.
  initial begin
    bit              held = 1'b0;
    logic [31:0]     hv;
    logic            hc;
    logic [3:0]      ht;
    exp_t            e;
    forever begin
      @(negedge clk); #2;
      if (mon_en) begin
        if (held) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_val2", 64'(val2), 64'(hv));
          check("stall_carry", 64'(carry_out), 64'(hc));
          check("stall_tag", 64'(tag_out), 64'(ht));
        end
        held = 1'b0;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output: got tag %0h expected no output", tag_out);
          end else begin
            e = sb.pop_front();
            check("sb_val2", 64'(val2), 64'(e.v));
            check("sb_carry", 64'(carry_out), 64'(e.c));
            check("sb_tag", 64'(tag_out), 64'(e.tag));
          end
        end else if (out_valid) begin
          held = 1'b1;
          hv = val2;
          hc = carry_out;
          ht = tag_out;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    fill_vecs();

    // Reset state.
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_val2", 64'(val2), 64'd0);
    check("rst_carry", 64'(carry_out), 64'd0);
    check("rst_tag", 64'(tag_out), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);

    single_op("lat_imm", 0, 4'hA);
    repeat (2) @(negedge clk);

    mon_en = 1'b1;
    stream(1'b0);
    stream(1'b1);
    mon_en = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Flush with one op stalled in S2 and one in S1.
    @(negedge clk); #1;
    out_ready = 1'b0;
    drive_vec(2, 4'h1);
    @(negedge clk); #1;
    drive_vec(3, 4'h2);
    @(negedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b1;
    #1 check("flush_pre_valid", 64'(out_valid), 64'd1);
    @(negedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    #1 check("flush_clear", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk); #2;
      if (out_valid) seen++;
    end
    check("flush_no_output", 64'(seen), 64'd0);
    single_op("post_flush", 14, 4'h7);

    // Asynchronous reset with two ops in flight.
    @(negedge clk); #1;
    out_ready = 1'b0;
    drive_vec(4, 4'h3);
    @(negedge clk); #1;
    drive_vec(5, 4'h4);
    @(negedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_val2", 64'(val2), 64'd0);
    check("mid_rst_tag", 64'(tag_out), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    #1 check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk); #2;
      if (out_valid) seen++;
    end
    check("mid_rst_no_output", 64'(seen), 64'd0);
    single_op("post_rst", 13, 4'h9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
